// File: rtl/rat_io_bridge.sv
// rat_io_bridge: port-mapped I/O bridge for the RAT MCU with output registers,
// synchronised input ports and a debounced, maskable rising-edge interrupt controller.
module rat_io_bridge #(
   parameter int         NUM_OUT     = 4,
   parameter int         NUM_IN      = 4,
   parameter int         NUM_IRQ     = 4,
   parameter logic [7:0] OUT_BASE_ID = 8'h40,
   parameter logic [7:0] IN_BASE_ID  = 8'h20,
   parameter logic [7:0] IRQ_STAT_ID = 8'hF0,
   parameter logic [7:0] IRQ_MASK_ID = 8'hF1,
   parameter logic [7:0] IRQ_ACK_ID  = 8'hF2,
   parameter int         DB_CYCLES   = 16
) (
   input  logic                 CLK,
   input  logic                 RESET_N,
   input  logic [7:0]           PORT_ID,
   input  logic [7:0]           OUT_PORT,
   input  logic                 IO_STRB,
   output logic [7:0]           IN_PORT,
   output logic                 INTV,
   input  logic [NUM_IN*8-1:0]  IN_DATA,
   output logic [NUM_OUT*8-1:0] OUT_DATA,
   input  logic [NUM_IRQ-1:0]   IRQ_SRC
);
   localparam int CW = $clog2(DB_CYCLES + 1);

   logic [NUM_OUT*8-1:0] out_q;
   logic [NUM_IN*8-1:0]  in_s1, in_s2;
   logic [NUM_IRQ-1:0]   irq_s1, irq_s2, deb, pending, mask, flip, ack;
   logic [CW-1:0]        cnt [NUM_IRQ];
   logic                 intv_q;
   logic [7:0]           rd;

   // flip marks the edge on which a source has differed for DB_CYCLES samples
   always_comb begin
      flip = '0;
      for (int i = 0; i < NUM_IRQ; i++)
         flip[i] = (irq_s2[i] != deb[i]) && (cnt[i] == CW'(DB_CYCLES - 1));
      ack = (IO_STRB && PORT_ID == IRQ_ACK_ID) ? OUT_PORT[NUM_IRQ-1:0] : '0;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         out_q   <= '0;
         in_s1   <= '0;
         in_s2   <= '0;
         irq_s1  <= '0;
         irq_s2  <= '0;
         deb     <= '0;
         pending <= '0;
         mask    <= '0;
         intv_q  <= 1'b0;
         for (int i = 0; i < NUM_IRQ; i++) cnt[i] <= '0;
      end else begin
         for (int k = 0; k < NUM_OUT; k++)
            if (IO_STRB && PORT_ID == 8'(OUT_BASE_ID + k)) out_q[8*k +: 8] <= OUT_PORT;
         in_s1  <= IN_DATA;
         in_s2  <= in_s1;
         irq_s1 <= IRQ_SRC;
         irq_s2 <= irq_s1;
         for (int i = 0; i < NUM_IRQ; i++)
            cnt[i] <= (irq_s2[i] == deb[i] || flip[i]) ? '0 : cnt[i] + 1'b1;
         deb <= deb ^ flip;
         // a new rising edge overrides a simultaneous acknowledge
         pending <= (pending & ~ack) | (flip & irq_s2);
         if (IO_STRB && PORT_ID == IRQ_MASK_ID) mask <= OUT_PORT[NUM_IRQ-1:0];
         intv_q <= |(pending & mask);
      end
   end

   always_comb begin
      rd = '0;
      for (int k = 0; k < NUM_IN; k++)
         if (PORT_ID == 8'(IN_BASE_ID + k)) rd = in_s2[8*k +: 8];
      if (PORT_ID == IRQ_STAT_ID) rd = 8'(pending);
      if (PORT_ID == IRQ_MASK_ID) rd = 8'(mask);
   end

   assign IN_PORT  = rd;
   assign INTV     = intv_q;
   assign OUT_DATA = out_q;
endmodule

// File: tb/tb_rat_io_bridge.sv
// tb_rat_io_bridge: vector table, directed interrupt sequences and randomized
// traffic checked against a window-based behavioural model of the bridge.
module tb_rat_io_bridge;
   localparam int         NO = 4, NI = 4, NQ = 4, DB = 4;
   localparam logic [7:0] OB = 8'h40, IB = 8'h20, ST = 8'hF0, MK = 8'hF1, AK = 8'hF2;

   logic        CLK = 1'b0, RESET_N = 1'b0, IO_STRB = 1'b0, INTV;
   logic [7:0]  PORT_ID = '0, OUT_PORT = '0, IN_PORT;
   logic [31:0] IN_DATA = '0, OUT_DATA;
   logic [3:0]  IRQ_SRC = '0;
   int          tests = 0, errs = 0;

   rat_io_bridge #(.NUM_OUT(NO), .NUM_IN(NI), .NUM_IRQ(NQ), .OUT_BASE_ID(OB), .IN_BASE_ID(IB),
      .IRQ_STAT_ID(ST), .IRQ_MASK_ID(MK), .IRQ_ACK_ID(AK), .DB_CYCLES(DB)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT), .IO_STRB(IO_STRB),
      .IN_PORT(IN_PORT), .INTV(INTV), .IN_DATA(IN_DATA), .OUT_DATA(OUT_DATA), .IRQ_SRC(IRQ_SRC));

   always #5 CLK = ~CLK;

   // reference model: a source's level flips once its last DB synchronised samples all disagree
   logic [7:0]  out_m [NO];
   logic [31:0] in_hist [2];
   logic [3:0]  raw_hist [DB+1];
   logic [3:0]  deb_m, pend_m, mask_m, flip_m, set_m, ack_m;
   logic        intv_m;

   always_comb begin
      flip_m = '1;
      for (int j = 1; j <= DB; j++) flip_m &= raw_hist[j] ^ deb_m;
      set_m = flip_m & ~deb_m;
      ack_m = (IO_STRB && PORT_ID == AK) ? OUT_PORT[3:0] : 4'h0;
   end

   always @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int k = 0; k < NO; k++) out_m[k] <= '0;
         in_hist[0] <= '0;
         in_hist[1] <= '0;
         for (int j = 0; j <= DB; j++) raw_hist[j] <= '0;
         deb_m  <= '0;
         pend_m <= '0;
         mask_m <= '0;
         intv_m <= 1'b0;
      end else begin
         for (int k = 0; k < NO; k++)
            if (IO_STRB && PORT_ID == 8'(OB + k)) out_m[k] <= OUT_PORT;
         in_hist[0]  <= IN_DATA;
         in_hist[1]  <= in_hist[0];
         raw_hist[0] <= IRQ_SRC;
         for (int j = 1; j <= DB; j++) raw_hist[j] <= raw_hist[j-1];
         deb_m  <= deb_m ^ flip_m;
         pend_m <= (pend_m & ~ack_m) | set_m;
         if (IO_STRB && PORT_ID == MK) mask_m <= OUT_PORT[3:0];
         intv_m <= |(pend_m & mask_m);
      end
   end

   function automatic logic [31:0] model_out();
      logic [31:0] v = '0;
      for (int k = 0; k < NO; k++) v[8*k +: 8] = out_m[k];
      return v;
   endfunction

   function automatic logic [7:0] model_rd(logic [7:0] id);
      logic [7:0] v = '0;
      for (int k = 0; k < NI; k++) if (id == 8'(IB + k)) v = in_hist[1][8*k +: 8];
      if (id == ST) v = {4'h0, pend_m};
      if (id == MK) v = {4'h0, mask_m};
      return v;
   endfunction

   function automatic bit id_clash();
      for (int id = 0; id < 256; id++) begin
         int n = 0;
         if (id >= OB && id < OB + NO) n++;
         if (id >= IB && id < IB + NI) n++;
         if (id == ST) n++;
         if (id == MK) n++;
         if (id == AK) n++;
         if (n > 1) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [7:0] id, input logic [7:0] d);
      IO_STRB = 1'b1; PORT_ID = id; OUT_PORT = d;
      @(negedge CLK);
      IO_STRB = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [7:0] id, input logic [7:0] exp);
      PORT_ID = id;
      #1 chk(name, {24'h0, IN_PORT}, {24'h0, exp});
   endtask

   typedef struct {
      logic        strb;
      logic [7:0]  id, data, rd, exp_rd;
      logic [31:0] exp_out;
   } vec_t;
   vec_t vecs [9];

   initial begin
      logic [7:0] rst_ids [5];
      vecs[0] = '{1'b1, 8'h42, 8'hA5, 8'h21, 8'h3C, 32'h00A5_0000};
      vecs[1] = '{1'b1, 8'h44, 8'hFF, 8'h99, 8'h00, 32'h00A5_0000};
      vecs[2] = '{1'b0, 8'h40, 8'h77, 8'h20, 8'h11, 32'h00A5_0000};
      vecs[3] = '{1'b1, 8'h40, 8'h5A, 8'h23, 8'h44, 32'h00A5_005A};
      vecs[4] = '{1'b1, 8'h43, 8'hC3, 8'h22, 8'h33, 32'hC3A5_005A};
      vecs[5] = '{1'b1, 8'hF1, 8'hFA, 8'hF1, 8'h0A, 32'hC3A5_005A};
      vecs[6] = '{1'b1, 8'hF1, 8'h00, 8'hF1, 8'h00, 32'hC3A5_005A};
      vecs[7] = '{1'b1, 8'hF2, 8'hFF, 8'hF2, 8'h00, 32'hC3A5_005A};
      vecs[8] = '{1'b1, 8'h41, 8'h01, 8'hF0, 8'h00, 32'hC3A5_015A};
      rst_ids = '{8'h20, 8'h21, 8'hF0, 8'hF1, 8'h40};
      if (id_clash()) begin
         $display("FAIL id_map: overlapping port IDs got 1 expected 0");
         $fatal(1);
      end
      IN_DATA = 32'h4433_3C11;
      repeat (2) @(negedge CLK);
      #1 chk("rst_out", OUT_DATA, 32'h0);
      chk("rst_intv", {31'h0, INTV}, 32'h0);
      foreach (rst_ids[i]) rd_chk("rst_rd", rst_ids[i], 8'h00);
      RESET_N = 1'b1;
      repeat (3) @(negedge CLK);
      foreach (vecs[i]) begin
         IO_STRB = vecs[i].strb; PORT_ID = vecs[i].id; OUT_PORT = vecs[i].data;
         @(negedge CLK);
         IO_STRB = 1'b0;
         rd_chk("vec_rd", vecs[i].rd, vecs[i].exp_rd);
         chk("vec_out", OUT_DATA, vecs[i].exp_out);
      end
      // short glitch is ignored, held level raises INTV DB+3 edges after the rise
      wr(MK, 8'h01);
      IRQ_SRC = 4'b0001;
      repeat (3) @(negedge CLK);
      IRQ_SRC = 4'b0000;
      repeat (10) @(negedge CLK);
      rd_chk("glitch_pend", ST, 8'h00);
      chk("glitch_intv", {31'h0, INTV}, 32'h0);
      IRQ_SRC = 4'b0001;
      repeat (6) @(negedge CLK);
      rd_chk("rise_pend", ST, 8'h01);
      chk("rise_intv_early", {31'h0, INTV}, 32'h0);
      @(negedge CLK);
      #1 chk("rise_intv", {31'h0, INTV}, 32'h1);
      // acknowledge, then a masked-out source that is enabled later
      wr(AK, 8'h01);
      rd_chk("ack_pend", ST, 8'h00);
      chk("ack_intv_lag", {31'h0, INTV}, 32'h1);
      @(negedge CLK);
      #1 chk("ack_intv", {31'h0, INTV}, 32'h0);
      IRQ_SRC = 4'b0101;
      repeat (8) @(negedge CLK);
      rd_chk("masked_pend", ST, 8'h04);
      chk("masked_intv", {31'h0, INTV}, 32'h0);
      wr(MK, 8'h04);
      #1 chk("unmask_intv_lag", {31'h0, INTV}, 32'h0);
      @(negedge CLK);
      #1 chk("unmask_intv", {31'h0, INTV}, 32'h1);
      // ack of bit 1 on the very edge it is set
      IRQ_SRC = 4'b0111;
      repeat (5) @(negedge CLK);
      IO_STRB = 1'b1; PORT_ID = AK; OUT_PORT = 8'h02;
      @(negedge CLK);
      IO_STRB = 1'b0;
      rd_chk("collide_pend", ST, 8'h06);
      chk("collide_intv", {31'h0, INTV}, 32'h1);
      @(negedge CLK);
      #1 chk("collide_intv2", {31'h0, INTV}, 32'h1);
      // asynchronous reset between edges with counters mid-count
      IRQ_SRC = 4'b0001;
      repeat (3) @(negedge CLK);
      #2 RESET_N = 1'b0;
      #1 chk("areset_intv", {31'h0, INTV}, 32'h0);
      chk("areset_out", OUT_DATA, 32'h0);
      rd_chk("areset_pend", ST, 8'h00);
      rd_chk("areset_mask", MK, 8'h00);
      @(negedge CLK);
      RESET_N = 1'b1;
      repeat (5) @(negedge CLK);
      rd_chk("rel_pend_early", ST, 8'h00);
      @(negedge CLK);
      rd_chk("rel_pend", ST, 8'h01);
      chk("rel_intv", {31'h0, INTV}, 32'h0);
      // randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         int sel;
         @(negedge CLK);
         #1 chk("rand_out", OUT_DATA, model_out());
         chk("rand_rd", {24'h0, IN_PORT}, {24'h0, model_rd(PORT_ID)});
         chk("rand_intv", {31'h0, INTV}, {31'h0, intv_m});
         sel = $urandom_range(0, 3);
         PORT_ID = sel == 0 ? 8'(OB + $urandom_range(0, 4)) :
                   sel == 1 ? 8'(IB + $urandom_range(0, 4)) :
                   sel == 2 ? 8'(ST + $urandom_range(0, 2)) : 8'($urandom);
         IO_STRB  = 1'($urandom_range(0, 1));
         OUT_PORT = 8'($urandom);
         if ($urandom_range(0, 3) == 0) IN_DATA = $urandom;
         for (int b = 0; b < NQ; b++) if ($urandom_range(0, 5) == 0) IRQ_SRC[b] = ~IRQ_SRC[b];
      end
      $display("[TB] %0d tests run, %0d failed", tests, errs);
      $finish;
   end
endmodule
